mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 133 +++++++++++++
 tb/tb_mult_div.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// rtl/mult_div.sv - iterative 32x32 multiply / divide unit for the EX stage
// Shift-add multiply and restoring divide on operand magnitudes, signs fixed up at the end.
module mult_div (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        flush,
    input  logic        ex_hold,
    output logic        done,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state;
    logic        op_div;
    logic        neg_res;
    logic        neg_rem;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [32:0] rem;

    // funct 0110xx covers MULT, MULTU, DIV, DIVU; bit1 selects divide, bit0 unsigned
    logic        is_md;
    logic        is_div;
    logic        is_signed;
    logic        start;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [33:0] diff;
    logic [63:0] partial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [63:0] prod_fix;

    assign is_md     = (funct[5:2] == 4'b0110);
    assign is_div    = funct[1];
    assign is_signed = ~funct[0];
    assign start     = (state == IDLE) && is_md && !flush;

    assign a_neg = is_signed & operand_1[31];
    assign b_neg = is_signed & operand_2[31];
    assign a_mag = a_neg ? -operand_1 : operand_1;
    assign b_mag = b_neg ? -operand_2 : operand_2;

    // mag_a doubles as the dividend shifter, and its low bits collect the quotient
    assign diff    = {rem, mag_a[31]} - {2'b00, mag_b};
    assign partial = mag_b[cnt[4:0]] ? ({32'h0, mag_a} << cnt[4:0]) : 64'h0;

    assign quo_fix  = neg_res ? -mag_a : mag_a;
    assign rem_fix  = neg_rem ? -rem[31:0] : rem[31:0];
    assign prod_fix = neg_res ? -acc : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            busy    <= 1'b0;
            result  <= 64'h0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            mag_a   <= 32'h0;
            mag_b   <= 32'h0;
            cnt     <= 6'd0;
            acc     <= 64'h0;
            rem     <= 33'h0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            cnt   <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div  <= is_div;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= is_div & a_neg;
                        mag_a   <= a_mag;
                        mag_b   <= b_mag;
                        cnt     <= 6'd0;
                        acc     <= 64'h0;
                        rem     <= 33'h0;
                        if (is_div && operand_2 == 32'h0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= {operand_1, 32'hFFFF_FFFF};
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (op_div) begin
                        rem   <= diff[33] ? {rem[31:0], mag_a[31]} : diff[32:0];
                        mag_a <= {mag_a[30:0], ~diff[33]};
                    end else begin
                        acc <= acc + partial;
                    end
                    if (cnt == 6'd31) begin
                        cnt   <= 6'd0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                FIX: begin
                    result <= op_div ? {rem_fix, quo_fix} : prod_fix;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                DONE: begin
                    if (!ex_hold) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - randomized and directed bench for mult_div against an arithmetic model
module tb_mult_div;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        ex_hold;
    logic        done;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    mult_div dut (
        .clk       (clk),
        .rst       (rst),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .ex_hold   (ex_hold),
        .done      (done),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic is_code(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        if ((f == F_DIV || f == F_DIVU) && b == 32'h0)
            return {a, 32'hFFFF_FFFF};
        case (f)
            F_MULT:  return 64'(sa * sb);
            F_MULTU: return ua * ub;
            F_DIV: begin
                sq = sa / sb;
                sr = sa % sb;
                q = 64'(sq);
                r = 64'(sr);
                return {r[31:0], q[31:0]};
            end
            default: begin
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: an op in flight completes 33 edges after its start edge; divide by zero completes at once
    logic        m_done = 1'b0;
    logic        m_busy = 1'b0;
    logic [63:0] m_res  = 64'h0;
    logic [63:0] m_pend = 64'h0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_done = 1'b0; m_busy = 1'b0; m_res = 64'h0; m_left = 0;
        end else if (flush) begin
            m_done = 1'b0; m_busy = 1'b0; m_left = 0;
        end else if (m_done) begin
            if (!ex_hold) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_res = m_pend;
            end
        end else if (is_code(funct)) begin
            if ((funct == F_DIV || funct == F_DIVU) && operand_2 == 32'h0) begin
                m_done = 1'b1; m_res = {operand_1, 32'hFFFF_FFFF};
            end else begin
                m_busy = 1'b1; m_left = 33; m_pend = ref_result(funct, operand_1, operand_2);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("done", {63'h0, done}, {63'h0, m_done});
            check("busy", {63'h0, busy}, {63'h0, m_busy});
            check("result", result, m_res);
        end
    end

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after done has fallen.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output int cyc, output int done_cnt, output logic [63:0] res);
        funct = f; operand_1 = a; operand_2 = b;
        cyc = 0;
        done_cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                operand_1 = $urandom;
                operand_2 = $urandom;
            end
        end while (!done && cyc < 60);
        if (!done) check("timeout", 64'(cyc), 64'd34);
        res = result;
        done_cnt = done ? 1 : 0;
        ex_hold = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        ex_hold = 1'b0;
        @(negedge clk);
        check("done_fall", {63'h0, done}, 64'h0);
    endtask

    task automatic idle(input int n);
        funct = 6'b000000;
        repeat (n) @(negedge clk);
    endtask

    int          cyc, dcnt;
    logic [63:0] res;
    logic [5:0]  rf;

    initial begin
        rst = 1'b1; funct = 6'b0; operand_1 = 32'h0; operand_2 = 32'h0; flush = 1'b0; ex_hold = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_result", result, 64'h0);
        rst = 1'b0;

        check("model_mult", ref_result(F_MULT, 32'hFFFF_FFFD, 32'h5), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model_multu", ref_result(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("model_div", ref_result(F_DIV, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_ovf", ref_result(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        check("model_divu", ref_result(F_DIVU, 32'd9, 32'd4), 64'h0000_0001_0000_0002);

        do_op(F_MULT, 32'hFFFF_FFFD, 32'h5, 0, cyc, dcnt, res);
        check("mult_latency", 64'(cyc), 64'd34);
        check("mult_res", res, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mult_done_cnt", 64'(dcnt), 64'd1);
        do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, dcnt, res);
        check("multu_max", res, 64'hFFFF_FFFE_0000_0001);
        do_op(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, dcnt, res);
        check("mult_m1", res, 64'h0000_0000_0000_0001);
        do_op(F_DIV, 32'hFFFF_FFF9, 32'h2, 0, cyc, dcnt, res);
        check("div_neg", res, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, dcnt, res);
        check("div_ovf", res, 64'h0000_0000_8000_0000);
        idle(2);
        do_op(F_DIVU, 32'd100, 32'd0, 0, cyc, dcnt, res);
        check("div0_latency", 64'(cyc), 64'd1);
        check("div0_res", res, 64'h0000_0064_FFFF_FFFF);

        do_op(F_MULTU, 32'd6, 32'd7, 3, cyc, dcnt, res);
        check("hold_done_cnt", 64'(dcnt), 64'd4);
        check("hold_res", result, 64'd42);

        funct = F_MULT; operand_1 = $urandom; operand_2 = $urandom;
        repeat (11) @(negedge clk);
        flush = 1'b1; funct = 6'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'h0, busy}, 64'h0);
        check("flush_done", {63'h0, done}, 64'h0);
        check("flush_result", result, 64'd42);
        repeat (40) begin
            @(negedge clk);
            if (done) check("flush_no_done", 64'h1, 64'h0);
        end
        do_op(F_MULTU, 32'd3, 32'd4, 0, cyc, dcnt, res);
        check("after_flush", res, 64'h0000_0000_0000_000C);

        funct = F_DIV; operand_1 = $urandom; operand_2 = 32'd3;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; funct = 6'b0;
        check("rstmid_done", {63'h0, done}, 64'h0);
        check("rstmid_busy", {63'h0, busy}, 64'h0);
        check("rstmid_result", result, 64'h0);
        do_op(F_DIVU, 32'd9, 32'd4, 0, cyc, dcnt, res);
        check("divu_9_4", res, 64'h0000_0001_0000_0002);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: rf = F_MULT;
                1: rf = F_MULTU;
                2: rf = F_DIV;
                default: rf = F_DIVU;
            endcase
            case ($urandom_range(0, 19))
                0: begin
                    rf = 6'($urandom);
                    if (is_code(rf)) rf = 6'b100001;
                    funct = rf;
                    repeat (3) @(negedge clk);
                    idle(1);
                end
                1: begin
                    funct = rf; operand_1 = rand_opnd(); operand_2 = rand_opnd();
                    repeat ($urandom_range(1, 36)) @(negedge clk);
                    flush = 1'b1; funct = 6'b0;
                    @(negedge clk);
                    flush = 1'b0;
                end
                default: do_op(rf, rand_opnd(), rand_opnd(), $urandom_range(0, 2), cyc, dcnt, res);
            endcase
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
